// File: rtl/ngs_pkg.sv
// Shared NGS memory-bus definitions: DMA FSM encoding, physical address width
// and the RAM chip-select decoder.
package ngs_pkg;

  localparam int PHYS_AW = 22;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WS   = 3'd3,
    WP   = 3'd4,
    WH   = 3'd5,
    REL  = 3'd6,
    FIN  = 3'd7
  } dma_state_e;

  function automatic logic [3:0] cs_dec(input logic [1:0] chip);
    logic [3:0] cs;
    cs       = 4'hF;
    cs[chip] = 1'b0;
    return cs;
  endfunction

endpackage

// File: rtl/dma_mem_ctl_busak_sync.sv
// Two-flop synchroniser for the Z80 busak_n line; resets to the released (1) level.
module busak_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/dma_mem_ctl.sv
// Z80-bus block-copy DMA: takes the bus, copies len bytes src->dst, releases it.
// Optional macro DMA_YIELD_EN gives the bus back to the Z80 every YIELD bytes.
module dma_mem_ctl
  import ngs_pkg::*;
#(
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
`ifdef DMA_YIELD_EN
  ,
  parameter int YIELD  = 256
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PHYS_AW-1:0] src,
  input  logic [PHYS_AW-1:0] dst,
  input  logic [15:0]        len,
  output logic               busy,
  output logic               done,
  output logic               busrq_n,
  input  logic               busak_n,
  output logic               bus_own,
  output logic [19:0]        mem_a,
  output logic [3:0]         ramcs_n,
  output logic               memoe_n,
  output logic               memwe_n,
  input  logic [7:0]         d_in,
  output logic [7:0]         d_out,
  output logic               d_oe
);

  localparam logic [7:0] RD_LAST = 8'(RD_CYC - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_CYC - 1);

  dma_state_e         state_q, state_d;
  logic [PHYS_AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [7:0]         data_q, data_d;
  logic               done_q, done_d;
  logic               busak_s;

`ifdef DMA_YIELD_EN
  localparam logic [15:0] YIELD_LAST = 16'(YIELD - 1);
  localparam logic [7:0]  GAP_CYC    = 8'd4;
  logic [15:0] ycnt_q, ycnt_d;
  logic        yld_q, yld_d;
`endif

  busak_sync u_busak_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(busak_n),
    .sync_o (busak_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef DMA_YIELD_EN
      ycnt_q  <= '0;
      yld_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef DMA_YIELD_EN
      ycnt_q  <= ycnt_d;
      yld_q   <= yld_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef DMA_YIELD_EN
    ycnt_d  = ycnt_q;
    yld_d   = yld_q;
`endif
    unique case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (start) begin
          if (len != 16'd0) begin
            src_d   = src;
            dst_d   = dst;
            len_d   = len;
            state_d = REQ;
`ifdef DMA_YIELD_EN
            ycnt_d  = '0;
`endif
          end else begin
            state_d = FIN;
          end
        end
      end
      REQ: begin
        wcnt_d = '0;
        if (!busak_s) state_d = RD;
      end
      RD: begin
        if (wcnt_q == RD_LAST) begin
          data_d  = d_in;
          wcnt_d  = '0;
          state_d = WS;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      WS: begin
        wcnt_d  = '0;
        state_d = WP;
      end
      WP: begin
        if (wcnt_q == WR_LAST) begin
          wcnt_d  = '0;
          state_d = WH;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      WH: begin
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
        len_d = len_q - 16'd1;
        if (len_q == 16'd1) begin
          state_d = REL;
        end else begin
`ifdef DMA_YIELD_EN
          if (ycnt_q == YIELD_LAST) begin
            ycnt_d  = '0;
            yld_d   = 1'b1;
            state_d = REL;
          end else begin
            ycnt_d  = ycnt_q + 16'd1;
            state_d = RD;
          end
`else
          state_d = RD;
`endif
        end
      end
      REL: begin
`ifdef DMA_YIELD_EN
        // On a yield, wcnt counts the idle cycles granted to the Z80 once it has the bus back.
        if (yld_q) begin
          if (wcnt_q != 8'd0) begin
            if (wcnt_q == GAP_CYC) begin
              yld_d   = 1'b0;
              wcnt_d  = '0;
              state_d = REQ;
            end else begin
              wcnt_d = wcnt_q + 8'd1;
            end
          end else if (busak_s) begin
            wcnt_d = 8'd1;
          end
        end else if (busak_s) begin
          state_d = FIN;
        end
`else
        if (busak_s) state_d = FIN;
`endif
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    busrq_n = 1'b1;
    bus_own = 1'b0;
    mem_a   = '0;
    ramcs_n = 4'hF;
    memoe_n = 1'b1;
    memwe_n = 1'b1;
    d_oe    = 1'b0;
    unique case (state_q)
      REQ: busrq_n = 1'b0;
      RD: begin
        busrq_n = 1'b0;
        bus_own = 1'b1;
        mem_a   = src_q[19:0];
        ramcs_n = cs_dec(src_q[21:20]);
        memoe_n = 1'b0;
      end
      WS, WP, WH: begin
        busrq_n = 1'b0;
        bus_own = 1'b1;
        mem_a   = dst_q[19:0];
        ramcs_n = cs_dec(dst_q[21:20]);
        memwe_n = (state_q != WP);
        d_oe    = 1'b1;
      end
      default: ;
    endcase
  end

  assign done  = done_q;
  assign d_out = data_q;

endmodule

// File: tb/tb_dma_mem_ctl.sv
// Directed self-checking bench for dma_mem_ctl with a Z80 bus-ack model and a 4-chip SRAM model.
module tb_dma_mem_ctl;

  localparam int RD_CYC = 2;
  localparam int WR_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [21:0] src = '0;
  logic [21:0] dst = '0;
  logic [15:0] len = '0;
  logic        busy, done, busrq_n, bus_own, memoe_n, memwe_n, d_oe;
  logic        busak_n = 1'b1;
  logic        akDly = 1'b1;
  logic [19:0] mem_a;
  logic [3:0]  ramcs_n;
  logic [7:0]  d_in = '0;
  logic [7:0]  d_out;

  int nCmp = 0;
  int nBad = 0;

  dma_mem_ctl #(
    .RD_CYC(RD_CYC),
    .WR_CYC(WR_CYC)
`ifdef DMA_YIELD_EN
    ,
    .YIELD (256)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .busrq_n(busrq_n), .busak_n(busak_n),
    .bus_own(bus_own), .mem_a(mem_a), .ramcs_n(ramcs_n), .memoe_n(memoe_n),
    .memwe_n(memwe_n), .d_in(d_in), .d_out(d_out), .d_oe(d_oe)
  );

  always #5 clk = ~clk;

  // Z80 grants/returns the bus two clocks after busrq_n changes.
  always @(posedge clk) begin
    akDly   <= busrq_n;
    busak_n <= akDly;
  end

  logic [7:0] mem [int];

  function automatic int chipOf(input logic [3:0] cs);
    case (cs)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] rdMem(input int key);
    if (mem.exists(key)) return mem[key];
    return 8'hxx;
  endfunction

  // Bus monitor: SRAM model, strobe pulse counting and protocol checks.
  int cyc = 0;
  int oePulses = 0, wePulses = 0, oeBadW = 0, weBadW = 0, protoErr = 0;
  int oeW = 0, weW = 0, doneCnt = 0, akRiseCyc = 0;
  logic prevAk = 1'b1;
  always @(negedge clk) begin
    int chip;
    cyc++;
    chip = chipOf(ramcs_n);
    if (!memoe_n && chip >= 0) d_in = rdMem(chip * 32'h100000 + int'(mem_a));
    else d_in = 8'h00;
    if (!memwe_n && d_oe && chip >= 0) mem[chip * 32'h100000 + int'(mem_a)] = d_out;
    if (!memoe_n) oeW++;
    else if (oeW != 0) begin oePulses++; if (oeW != RD_CYC) oeBadW++; oeW = 0; end
    if (!memwe_n) weW++;
    else if (weW != 0) begin wePulses++; if (weW != WR_CYC) weBadW++; weW = 0; end
    if (!memoe_n && !memwe_n) protoErr++;
    if (!memoe_n && d_oe) protoErr++;
    if (done) doneCnt++;
    if (busak_n && !prevAk) akRiseCyc = cyc;
    prevAk = busak_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input logic [21:0] s, input logic [21:0] d, input logic [15:0] n);
    src = s; dst = d; len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    nCmp++; if (busy !== 1'b0)    begin nBad++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    nCmp++; if (done !== 1'b0)    begin nBad++; $display("[TB] FAIL rst_done got %b want 0", done); end
    nCmp++; if (busrq_n !== 1'b1) begin nBad++; $display("[TB] FAIL rst_busrq_n got %b want 1", busrq_n); end
    nCmp++; if (bus_own !== 1'b0) begin nBad++; $display("[TB] FAIL rst_bus_own got %b want 0", bus_own); end
    nCmp++; if (ramcs_n !== 4'hF) begin nBad++; $display("[TB] FAIL rst_ramcs_n got %h want F", ramcs_n); end
    nCmp++; if (memoe_n !== 1'b1) begin nBad++; $display("[TB] FAIL rst_memoe_n got %b want 1", memoe_n); end
    nCmp++; if (memwe_n !== 1'b1) begin nBad++; $display("[TB] FAIL rst_memwe_n got %b want 1", memwe_n); end
    nCmp++; if (d_oe !== 1'b0)    begin nBad++; $display("[TB] FAIL rst_d_oe got %b want 0", d_oe); end
    nCmp++; if (mem_a !== 20'h0)  begin nBad++; $display("[TB] FAIL rst_mem_a got %h want 0", mem_a); end
    nCmp++; if (d_out !== 8'h00)  begin nBad++; $display("[TB] FAIL rst_d_out got %h want 00", d_out); end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic_copy();
    int oe0, we0, bw0, pe0, dn0, doneAt;
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) mem[32'h100 + i] = exp[i];
    oe0 = oePulses; we0 = wePulses; bw0 = oeBadW + weBadW; pe0 = protoErr; dn0 = doneCnt;
    doneAt = -1;
    kick(22'h000100, 22'h100200, 16'd4);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) begin doneAt = cyc; break; end
    end
    nCmp++; if (doneAt < 0) begin nBad++; $display("[TB] FAIL basic_timeout got no done want done"); end
    // busak_n rise -> two sync flops -> REL->FIN -> FIN->done register: 4 cycles.
    nCmp++; if (doneAt - akRiseCyc != 4) begin nBad++; $display("[TB] FAIL basic_done_lat got %0d want 4", doneAt - akRiseCyc); end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      nCmp++;
      if (rdMem(32'h100200 + i) !== exp[i])
        begin nBad++; $display("[TB] FAIL basic_data[%0d] got %h want %h", i, rdMem(32'h100200 + i), exp[i]); end
    end
    nCmp++; if (oePulses - oe0 != 4) begin nBad++; $display("[TB] FAIL basic_oe_pulses got %0d want 4", oePulses - oe0); end
    nCmp++; if (wePulses - we0 != 4) begin nBad++; $display("[TB] FAIL basic_we_pulses got %0d want 4", wePulses - we0); end
    nCmp++; if (oeBadW + weBadW - bw0 != 0) begin nBad++; $display("[TB] FAIL basic_pulse_width got %0d bad want 0", oeBadW + weBadW - bw0); end
    nCmp++; if (protoErr - pe0 != 0) begin nBad++; $display("[TB] FAIL basic_strobe_overlap got %0d want 0", protoErr - pe0); end
    nCmp++; if (doneCnt - dn0 != 1) begin nBad++; $display("[TB] FAIL basic_done_count got %0d want 1", doneCnt - dn0); end
  endtask

  task automatic test_len_zero();
    src = 22'h000000; dst = 22'h000000; len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    nCmp++; if (busy !== 1'b1)    begin nBad++; $display("[TB] FAIL len0_busy1 got %b want 1", busy); end
    nCmp++; if (done !== 1'b0)    begin nBad++; $display("[TB] FAIL len0_done1 got %b want 0", done); end
    nCmp++; if (busrq_n !== 1'b1) begin nBad++; $display("[TB] FAIL len0_busrq_n got %b want 1", busrq_n); end
    tick();
    nCmp++; if (busy !== 1'b0)    begin nBad++; $display("[TB] FAIL len0_busy2 got %b want 0", busy); end
    nCmp++; if (done !== 1'b1)    begin nBad++; $display("[TB] FAIL len0_done2 got %b want 1", done); end
    tick();
    nCmp++; if (done !== 1'b0)    begin nBad++; $display("[TB] FAIL len0_done3 got %b want 0", done); end
    nCmp++; if (busrq_n !== 1'b1) begin nBad++; $display("[TB] FAIL len0_busrq_n_end got %b want 1", busrq_n); end
    repeat (2) tick();
  endtask

  task automatic wrapCase(input logic [21:0] s, input logic [21:0] d,
                          input logic [3:0] cs0, input logic [19:0] a0,
                          input logic [3:0] cs1, input logic [19:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1);
    logic [3:0]  rdCs [2];
    logic [19:0] rdA [2];
    int nRd;
    logic prevOe;
    nRd = 0; prevOe = 1'b1;
    rdCs[0] = 'x; rdCs[1] = 'x; rdA[0] = 'x; rdA[1] = 'x;
    kick(s, d, 16'd2);
    for (int i = 0; i < 300; i++) begin
      if (!memoe_n && prevOe && nRd < 2) begin rdCs[nRd] = ramcs_n; rdA[nRd] = mem_a; nRd++; end
      prevOe = memoe_n;
      if (done) break;
      tick();
    end
    nCmp++; if (rdCs[0] !== cs0) begin nBad++; $display("[TB] FAIL wrap_cs0 got %b want %b", rdCs[0], cs0); end
    nCmp++; if (rdA[0] !== a0)   begin nBad++; $display("[TB] FAIL wrap_a0 got %h want %h", rdA[0], a0); end
    nCmp++; if (rdCs[1] !== cs1) begin nBad++; $display("[TB] FAIL wrap_cs1 got %b want %b", rdCs[1], cs1); end
    nCmp++; if (rdA[1] !== a1)   begin nBad++; $display("[TB] FAIL wrap_a1 got %h want %h", rdA[1], a1); end
    nCmp++; if (rdMem(int'(d)) !== b0)     begin nBad++; $display("[TB] FAIL wrap_d0 got %h want %h", rdMem(int'(d)), b0); end
    nCmp++; if (rdMem(int'(d) + 1) !== b1) begin nBad++; $display("[TB] FAIL wrap_d1 got %h want %h", rdMem(int'(d) + 1), b1); end
    repeat (3) tick();
  endtask

  task automatic test_chip_wrap();
    mem[32'h0FFFFF] = 8'hA5; mem[32'h100000] = 8'h5A;
    wrapCase(22'h0FFFFF, 22'h200000, 4'b1110, 20'hFFFFF, 4'b1101, 20'h00000, 8'hA5, 8'h5A);
    mem[32'h3FFFFF] = 8'h77; mem[32'h000000] = 8'h88;
    wrapCase(22'h3FFFFF, 22'h280000, 4'b0111, 20'hFFFFF, 4'b1110, 20'h00000, 8'h77, 8'h88);
  endtask

  task automatic test_back_to_back();
    int we0, dn0;
    logic [7:0] exp [3] = '{8'hC1, 8'hC2, 8'hC3};
    for (int i = 0; i < 3; i++) mem[32'h000300 + i] = exp[i];
    we0 = wePulses; dn0 = doneCnt;
    kick(22'h000300, 22'h300400, 16'd3);
    repeat (5) tick();
    nCmp++; if (busy !== 1'b1) begin nBad++; $display("[TB] FAIL b2b_busy got %b want 1", busy); end
    kick(22'h000100, 22'h300000, 16'd5);
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      tick();
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      nCmp++;
      if (rdMem(32'h300400 + i) !== exp[i])
        begin nBad++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, rdMem(32'h300400 + i), exp[i]); end
    end
    nCmp++; if (mem.exists(32'h300000) != 0) begin nBad++; $display("[TB] FAIL b2b_stray_write got 1 want 0"); end
    nCmp++; if (wePulses - we0 != 3) begin nBad++; $display("[TB] FAIL b2b_we_pulses got %0d want 3", wePulses - we0); end
    nCmp++; if (doneCnt - dn0 != 1) begin nBad++; $display("[TB] FAIL b2b_done_count got %0d want 1", doneCnt - dn0); end
  endtask

  task automatic test_reset_mid_job();
    bit hit;
    int dn0;
    hit = 1'b0;
    kick(22'h000500, 22'h100600, 16'd4);
    for (int i = 0; i < 200; i++) begin
      if (!memwe_n) begin hit = 1'b1; break; end
      tick();
    end
    nCmp++; if (!hit) begin nBad++; $display("[TB] FAIL midrst_reach_wp got 0 want 1"); end
    dn0 = doneCnt;
    rst = 1'b1;
    tick();
    nCmp++; if (memwe_n !== 1'b1) begin nBad++; $display("[TB] FAIL midrst_memwe_n got %b want 1", memwe_n); end
    nCmp++; if (busrq_n !== 1'b1) begin nBad++; $display("[TB] FAIL midrst_busrq_n got %b want 1", busrq_n); end
    nCmp++; if (bus_own !== 1'b0) begin nBad++; $display("[TB] FAIL midrst_bus_own got %b want 0", bus_own); end
    nCmp++; if (busy !== 1'b0)    begin nBad++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    nCmp++; if (done !== 1'b0)    begin nBad++; $display("[TB] FAIL midrst_done got %b want 0", done); end
    rst = 1'b0;
    repeat (10) tick();
    nCmp++; if (doneCnt - dn0 != 0) begin nBad++; $display("[TB] FAIL midrst_no_done got %0d want 0", doneCnt - dn0); end
  endtask

`ifdef DMA_YIELD_EN
  task automatic test_yield();
    int nFall, weAtFall, dn0, badData, badGap, busyDrop;
    int bytes [3];
    logic prevRq;
    bit fin;
    for (int i = 0; i < 600; i++) mem[32'h010000 + i] = 8'(i) ^ 8'h5A;
    nFall = 0; weAtFall = 0; badGap = 0; busyDrop = 0; prevRq = 1'b1; fin = 1'b0;
    bytes[0] = -1; bytes[1] = -1; bytes[2] = -1;
    dn0 = doneCnt;
    kick(22'h010000, 22'h120000, 16'd600);
    for (int i = 0; i < 8000; i++) begin
      if (done) begin fin = 1'b1; break; end
      if (!busy) busyDrop++;
      if (!busrq_n && prevRq) begin
        if (nFall > 0 && cyc - akRiseCyc < 4) badGap++;
        weAtFall = wePulses;
        nFall++;
      end
      if (busrq_n && !prevRq && nFall >= 1 && nFall <= 3) bytes[nFall - 1] = wePulses - weAtFall;
      prevRq = busrq_n;
      tick();
    end
    repeat (3) tick();
    badData = 0;
    for (int i = 0; i < 600; i++) if (rdMem(32'h120000 + i) !== (8'(i) ^ 8'h5A)) badData++;
    nCmp++; if (!fin) begin nBad++; $display("[TB] FAIL yield_timeout got no done want done"); end
    nCmp++; if (nFall != 3) begin nBad++; $display("[TB] FAIL yield_tenures got %0d want 3", nFall); end
    nCmp++; if (bytes[0] != 256) begin nBad++; $display("[TB] FAIL yield_bytes0 got %0d want 256", bytes[0]); end
    nCmp++; if (bytes[1] != 256) begin nBad++; $display("[TB] FAIL yield_bytes1 got %0d want 256", bytes[1]); end
    nCmp++; if (bytes[2] != 88)  begin nBad++; $display("[TB] FAIL yield_bytes2 got %0d want 88", bytes[2]); end
    nCmp++; if (badGap != 0)   begin nBad++; $display("[TB] FAIL yield_gap got %0d short want 0", badGap); end
    nCmp++; if (busyDrop != 0) begin nBad++; $display("[TB] FAIL yield_busy got %0d low cycles want 0", busyDrop); end
    nCmp++; if (badData != 0)  begin nBad++; $display("[TB] FAIL yield_data got %0d bad bytes want 0", badData); end
    nCmp++; if (doneCnt - dn0 != 1) begin nBad++; $display("[TB] FAIL yield_done_count got %0d want 1", doneCnt - dn0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_copy();
    test_len_zero();
    test_chip_wrap();
    test_back_to_back();
    test_reset_mid_job();
`ifdef DMA_YIELD_EN
    test_yield();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
